mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage sitting between EXE and WB. It receives one instruction at a time from EXE, collects the data-SRAM response for the load/store request EXE already issued, and aligns and extends load data. It produces the `{we, waddr, wdata}` register-write bundle and PC that WB consumes over a valid/allow-in handshake. It also exports a forwarding/stall bus for ID.

## Interface
- No parameters.
- `clk` in 1: stage clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low; all registers clear while low.
- `MEM_allow_in` out 1: MEM can accept an instruction this cycle.
- `EXE_MEM_valid` in 1: EXE presents a valid instruction.
- `EXE_pc` in 32: PC of the EXE instruction.
- `EXE_rf` in 38: `{we[37], waddr[36:32], result[31:0]}`. `result` is the effective address for memory ops.
- `EXE_mem` in 5: `{req[4], load[3], sign[2], size[1:0]}`, with size 00 = byte, 01 = half, 10 = word. `req` = 1 means EXE issued a data-SRAM request (load or store).
- `data_sram_data_ok` in 1: one pulse per request, in request order.
- `data_sram_rdata` in 32: read data, valid with `data_ok`.
- `WB_allow_in` in 1: WB can accept.
- `MEM_WB_valid` out 1: MEM output valid.
- `MEM_pc` out 32: PC of the MEM instruction.
- `MEM_rf` out 38: `{we, waddr, wdata}` toward WB.
- `MEM_fwd` out 39: `{load_pending[38], we[37], waddr[36:32], wdata[31:0]}` toward ID.

## Operation
- Latch: when `EXE_MEM_valid & MEM_allow_in`, register `EXE_pc`, `EXE_rf`, and `EXE_mem`, and clear `resp_got`.
- `MEM_valid`: set to `EXE_MEM_valid` whenever `MEM_allow_in` is high; otherwise hold.
- Response capture: when `MEM_valid & req & ~resp_got & data_sram_data_ok`:
  - If WB does not accept this cycle (`WB_allow_in` low), latch `data_sram_rdata` into `resp_buf` and set `resp_got`.
  - If WB accepts this cycle, use the data combinationally and buffer nothing.
- Ignored responses: a `data_ok` pulse outside that condition is ignored and is an assertion failure.
- Handshake signals:
  - `ready_go = ~req | resp_got | data_sram_data_ok`.
  - `MEM_WB_valid = MEM_valid & ready_go`.
  - `MEM_allow_in = ~MEM_valid | (ready_go & WB_allow_in)`.
- Load data source: `ld_raw = resp_got ? resp_buf : data_sram_rdata`. Let `a = result[1:0]`.
  - Byte: `ld_raw[8a+7:8a]`.
  - Half: `a[1] ? ld_raw[31:16] : ld_raw[15:0]`.
  - Word: `ld_raw`, with `a` ignored.
  - Extension: sign-extend if `sign`, else zero-extend.
  - Misalignment is not checked here; EXE guarantees alignment.
- Write data: `wdata = load ? aligned : result`. Stores and non-memory ops pass `result` through, and stores carry `we` = 0 from EXE.
- Outputs:
  - `MEM_rf = {we, waddr, wdata}`, not masked by valid; WB masks.
  - `MEM_fwd.we = we & MEM_valid`.
  - `load_pending = MEM_valid & load & ~ready_go`; ID must stall on an address match while this is high.

## Timing
- Reset values while `rst` is low: `MEM_valid` = 0, `resp_got` = 0, pc/rf/mem/`resp_buf` registers = 0.
  - Hence `MEM_WB_valid` = 0, `MEM_allow_in` = 1, `MEM_pc` = 0, `MEM_rf` = 0, `MEM_fwd` = 0.
- Non-memory instruction: one cycle in MEM; `MEM_WB_valid` is high the cycle after acceptance.
- Memory op with `data_ok` N cycles after acceptance (N ≥ 0): `MEM_WB_valid` rises in the `data_ok` cycle (combinational path). WB captures it at the next edge if `WB_allow_in` is high.
- Back-pressure: if `WB_allow_in` is low, all outputs hold stable and `MEM_allow_in` = 0 while `MEM_valid`.
- Buffered response: `resp_buf` holds the response until transfer, and any later `data_ok` belongs to the next instruction.
- Transfer-and-accept: if the current instruction leaves MEM in the same cycle a new one is accepted, the new instruction replaces state at the edge and `resp_got` clears.
- Reset mid-wait: valid and buffer clear immediately; the memory side is reset by the same `rst`, so no stale response follows.

## Test plan
- ALU op: `EXE_rf` = `{1,5'd4,32'h1234}`, `req` = 0 → next cycle `MEM_WB_valid` = 1, `MEM_rf` = `{1,4,32'h1234}`, `MEM_fwd[38]` = 0.
- `ld.b`, addr `0x...03`, rdata `0x80FF_0000`, sign = 1; `data_ok` two cycles late → `load_pending` = 1 for 2 cycles, then wdata = `0xFFFF_FF80`.
- `ld.hu`, addr offset 2, rdata `0x8001_7FFF` → wdata = `0x0000_8001`; `ld.w` → `0x8001_7FFF`.
- `WB_allow_in` = 0 for 3 cycles; `data_ok` arrives in the first → `resp_buf` holds the data, `MEM_allow_in` = 0, `MEM_rf` is stable, and the transfer happens on the cycle `WB_allow_in` rises.
- Back-to-back loads with `data_ok` every cycle → one instruction per cycle to WB, with no dropped or duplicated response.
- Assert `rst` low while a load waits → `MEM_WB_valid` = 0 immediately, and all outputs are 0 after release.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EXE and WB: collects the data-SRAM
// response, aligns/extends load data and hands {we, waddr, wdata} to WB.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  output logic        MEM_allow_in,
  input  logic        EXE_MEM_valid,
  input  logic [31:0] EXE_pc,
  input  logic [37:0] EXE_rf,
  input  logic [4:0]  EXE_mem,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        WB_allow_in,
  output logic        MEM_WB_valid,
  output logic [31:0] MEM_pc,
  output logic [37:0] MEM_rf,
  output logic [38:0] MEM_fwd
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef struct packed {
    logic        req;
    logic        load;
    logic        sign;
    logic [1:0]  size;
  } mem_ctl_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] result;
  } rf_t;

  logic        mem_valid;
  logic        resp_got;
  logic [31:0] pc_q;
  logic [31:0] resp_buf;
  rf_t         rf_q;
  mem_ctl_t    mem_q;

  logic        ready_go;
  logic        accept;
  logic        capture;
  logic        load_pending;
  logic [31:0] ld_raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] aligned;
  logic [31:0] wdata;

  assign ready_go     = ~mem_q.req | resp_got | data_sram_data_ok;
  assign MEM_WB_valid = mem_valid & ready_go;
  assign MEM_allow_in = ~mem_valid | (ready_go & WB_allow_in);
  assign accept       = EXE_MEM_valid & MEM_allow_in;
  // A response is parked only when WB stalls; otherwise it is consumed
  // combinationally in the cycle it arrives.
  assign capture      = mem_valid & mem_q.req & ~resp_got & data_sram_data_ok & ~WB_allow_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid <= 1'b0;
      resp_got  <= 1'b0;
      pc_q      <= '0;
      rf_q      <= '0;
      mem_q     <= '0;
      resp_buf  <= '0;
    end else begin
      if (MEM_allow_in) begin
        mem_valid <= EXE_MEM_valid;
      end
      // accept and capture are exclusive: capture needs WB stalled, which
      // keeps MEM_allow_in low while an instruction is held.
      if (accept) begin
        pc_q     <= EXE_pc;
        rf_q     <= EXE_rf;
        mem_q    <= EXE_mem;
        resp_got <= 1'b0;
      end else if (capture) begin
        resp_buf <= data_sram_rdata;
        resp_got <= 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statements can infer a latch.
  always_comb begin
    ld_raw  = resp_got ? resp_buf : data_sram_rdata;
    ld_byte = ld_raw[7:0];
    case (rf_q.result[1:0])
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      2'd3:    ld_byte = ld_raw[31:24];
      default: ld_byte = ld_raw[7:0];
    endcase
    ld_half = rf_q.result[1] ? ld_raw[31:16] : ld_raw[15:0];

    aligned = ld_raw;
    case (mem_q.size)
      SZ_BYTE: aligned = {{24{mem_q.sign & ld_byte[7]}}, ld_byte};
      SZ_HALF: aligned = {{16{mem_q.sign & ld_half[15]}}, ld_half};
      default: aligned = ld_raw;
    endcase

    wdata = mem_q.load ? aligned : rf_q.result;
  end

  assign load_pending = mem_valid & mem_q.load & ~ready_go;

  assign MEM_pc  = pc_q;
  assign MEM_rf  = {rf_q.we, rf_q.waddr, wdata};
  assign MEM_fwd = {load_pending, rf_q.we & mem_valid, rf_q.waddr, wdata};

`ifndef SYNTHESIS
  // Responses arrive in request order, so one landing while nothing is
  // waiting for it means the memory side and this stage disagree.
  a_data_ok_expected: assert property (@(posedge clk) disable iff (!rst)
    data_sram_data_ok |-> (mem_valid & mem_q.req & ~resp_got));
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table of single transactions,
// hand sequences for back-pressure, back-to-back loads and reset mid-wait.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        MEM_allow_in;
  logic        EXE_MEM_valid;
  logic [31:0] EXE_pc;
  logic [37:0] EXE_rf;
  logic [4:0]  EXE_mem;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        WB_allow_in;
  logic        MEM_WB_valid;
  logic [31:0] MEM_pc;
  logic [37:0] MEM_rf;
  logic [38:0] MEM_fwd;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .MEM_allow_in      (MEM_allow_in),
    .EXE_MEM_valid     (EXE_MEM_valid),
    .EXE_pc            (EXE_pc),
    .EXE_rf            (EXE_rf),
    .EXE_mem           (EXE_mem),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .WB_allow_in       (WB_allow_in),
    .MEM_WB_valid      (MEM_WB_valid),
    .MEM_pc            (MEM_pc),
    .MEM_rf            (MEM_rf),
    .MEM_fwd           (MEM_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [37:0] rf;
    logic [4:0]  mem;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_wdata;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  logic [69:0] exp_q[$];
  logic [69:0] cur_exp;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    EXE_MEM_valid     = 1'b0;
    EXE_pc            = '0;
    EXE_rf            = '0;
    EXE_mem           = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    WB_allow_in       = 1'b1;
  endtask

  // Independent reference for load alignment and extension.
  function automatic logic [31:0] load_model(input logic [31:0] d, input logic [1:0] a,
                                             input logic [4:0] m);
    logic [31:0] v;
    logic [31:0] mask;
    int          bits;
    bits = (m[1:0] == 2'b00) ? 8 : (m[1:0] == 2'b01) ? 16 : 32;
    if (bits == 32) return d;
    v    = d >> (8 * a);
    mask = (32'h1 << bits) - 32'h1;
    v    = v & mask;
    if (m[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // Scoreboard: push on acceptance, pop and compare on transfer to WB.
  always @(negedge clk) begin
    if (rst) begin
      if (MEM_WB_valid && WB_allow_in) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_xfer", {MEM_pc, MEM_rf}, 70'h0);
        end else begin
          check("sb_xfer", {MEM_pc, MEM_rf}, exp_q.pop_front());
        end
      end
      if (EXE_MEM_valid && MEM_allow_in) exp_q.push_back(cur_exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Caller is at posedge+1 with idle inputs; returns at posedge+1, idle.
  task automatic run_txn(input vec_t v);
    EXE_MEM_valid = 1'b1;
    EXE_pc        = v.pc;
    EXE_rf        = v.rf;
    EXE_mem       = v.mem;
    WB_allow_in   = 1'b1;
    cur_exp       = {v.pc, v.rf[37:32], v.exp_wdata};
    #1;
    check("txn_allow_in", MEM_allow_in, 1'b1);
    next_cycle();
    EXE_MEM_valid = 1'b0;
    if (v.mem[4]) begin
      for (int i = 0; i < v.delay; i++) begin
        #1;
        check("txn_wait_valid", MEM_WB_valid, 1'b0);
        check("txn_load_pending", MEM_fwd[38], v.mem[3]);
        check("txn_fwd_we", MEM_fwd[37], v.rf[37]);
        next_cycle();
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = v.rdata;
    end
    #1;
    check("txn_out_valid", MEM_WB_valid, 1'b1);
    check("txn_pending_clear", MEM_fwd[38], 1'b0);
    check("txn_fwd_wdata", MEM_fwd[31:0], v.exp_wdata);
    next_cycle();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
  endtask

  vec_t        vecs[10];
  logic [37:0] snap;
  int          x0;
  logic [31:0] bb_rdata[5];
  logic [4:0]  bb_mem[5];

  initial begin
    vecs[0] = '{32'h0000_0100, {1'b1, 5'd4,  32'h0000_1234}, 5'b00000, 32'h0000_0000, 0, 32'h0000_1234};
    vecs[1] = '{32'h0000_0104, {1'b1, 5'd7,  32'h1000_0003}, 5'b11100, 32'h80FF_0000, 2, 32'hFFFF_FF80};
    vecs[2] = '{32'h0000_0108, {1'b1, 5'd8,  32'h2000_0002}, 5'b11001, 32'h8001_7FFF, 1, 32'h0000_8001};
    vecs[3] = '{32'h0000_010C, {1'b1, 5'd8,  32'h2000_0000}, 5'b11010, 32'h8001_7FFF, 0, 32'h8001_7FFF};
    vecs[4] = '{32'h0000_0110, {1'b1, 5'd5,  32'h2000_0010}, 5'b11101, 32'h1234_8001, 3, 32'hFFFF_8001};
    vecs[5] = '{32'h0000_0114, {1'b1, 5'd6,  32'h2000_0021}, 5'b11000, 32'h1234_A5C3, 0, 32'h0000_00A5};
    vecs[6] = '{32'h0000_0118, {1'b1, 5'd2,  32'h2000_0030}, 5'b11100, 32'h0000_007F, 1, 32'h0000_007F};
    vecs[7] = '{32'h0000_011C, {1'b0, 5'd3,  32'h3000_0004}, 5'b10010, 32'hCAFE_F00D, 2, 32'h3000_0004};
    vecs[8] = '{32'h0000_0120, {1'b1, 5'd12, 32'h2000_0042}, 5'b11101, 32'h8765_0000, 0, 32'hFFFF_8765};
    vecs[9] = '{32'h0000_0124, {1'b0, 5'd1,  32'hABCD_0000}, 5'b00000, 32'h0000_0000, 0, 32'hABCD_0000};

    cur_exp = '0;
    rst     = 1'b0;
    idle_inputs();
    #12;
    check("reset_wb_valid", MEM_WB_valid, 1'b0);
    check("reset_allow_in", MEM_allow_in, 1'b1);
    check("reset_pc", MEM_pc, 32'h0);
    check("reset_rf", MEM_rf, 38'h0);
    check("reset_fwd", MEM_fwd, 39'h0);
    #10;
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // WB stalls three cycles, response arrives in the first of them.
    EXE_MEM_valid = 1'b1;
    EXE_pc        = 32'h0000_0200;
    EXE_rf        = {1'b1, 5'd9, 32'h0000_0040};
    EXE_mem       = 5'b11010;
    cur_exp       = {32'h0000_0200, 1'b1, 5'd9, 32'hDEAD_BEEF};
    next_cycle();
    EXE_MEM_valid     = 1'b0;
    WB_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check("bp_valid", MEM_WB_valid, 1'b1);
    check("bp_allow_in", MEM_allow_in, 1'b0);
    check("bp_rf", MEM_rf, {1'b1, 5'd9, 32'hDEAD_BEEF});
    snap = MEM_rf;
    next_cycle();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0BAD_0BAD;
    EXE_MEM_valid     = 1'b1;
    EXE_pc            = 32'h0000_0204;
    EXE_rf            = {1'b1, 5'd10, 32'h0000_0050};
    EXE_mem           = 5'b11000;
    cur_exp           = {32'h0000_0204, 1'b1, 5'd10, 32'h0000_0011};
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bp_hold_valid", MEM_WB_valid, 1'b1);
      check("bp_hold_allow_in", MEM_allow_in, 1'b0);
      check("bp_hold_rf", MEM_rf, snap);
      check("bp_hold_pc", MEM_pc, 32'h0000_0200);
      next_cycle();
    end
    WB_allow_in = 1'b1;
    #1;
    check("bp_release_allow_in", MEM_allow_in, 1'b1);
    check("bp_release_rf", MEM_rf, snap);
    next_cycle();
    EXE_MEM_valid = 1'b0;
    #1;
    check("tna_new_waits", MEM_WB_valid, 1'b0);
    check("tna_new_pending", MEM_fwd[38], 1'b1);
    check("tna_new_pc", MEM_pc, 32'h0000_0204);
    next_cycle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5566_7711;
    #1;
    check("tna_new_valid", MEM_WB_valid, 1'b1);
    next_cycle();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;

    // Back-to-back loads, one response per cycle.
    for (int k = 0; k < 5; k++) begin
      bb_rdata[k] = 32'h807F_C301 + 32'h1357_9BDF * k;
      bb_mem[k]   = (k % 2 == 0) ? 5'b11100 : 5'b11010;
    end
    x0 = n_xfer;
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        EXE_MEM_valid = 1'b1;
        EXE_pc        = 32'h0000_0300 + 32'(4 * k);
        EXE_rf        = {1'b1, 5'(11 + k), 32'h0000_0100 + 32'(k)};
        EXE_mem       = bb_mem[k];
        cur_exp       = {EXE_pc, 1'b1, 5'(11 + k),
                         load_model(bb_rdata[k], 2'(k), bb_mem[k])};
      end else begin
        EXE_MEM_valid = 1'b0;
      end
      if (k > 0) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = bb_rdata[k-1];
      end
      #1;
      if (k > 0) begin
        check("b2b_valid", MEM_WB_valid, 1'b1);
        check("b2b_allow_in", MEM_allow_in, 1'b1);
      end
      next_cycle();
    end
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    check("b2b_xfer_count", 32'(n_xfer - x0), 32'd5);
    check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset while a load is waiting for its response.
    EXE_MEM_valid = 1'b1;
    EXE_pc        = 32'h0000_0400;
    EXE_rf        = {1'b1, 5'd20, 32'h0000_0080};
    EXE_mem       = 5'b11010;
    cur_exp       = {32'h0000_0400, 1'b1, 5'd20, 32'h0};
    next_cycle();
    EXE_MEM_valid = 1'b0;
    #1;
    check("rst_pre_pending", MEM_fwd[38], 1'b1);
    next_cycle();
    idle_inputs();
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("rst_mid_wb_valid", MEM_WB_valid, 1'b0);
    check("rst_mid_allow_in", MEM_allow_in, 1'b1);
    check("rst_mid_fwd", MEM_fwd, 39'h0);
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_after_wb_valid", MEM_WB_valid, 1'b0);
      check("rst_after_pc", MEM_pc, 32'h0);
      check("rst_after_rf", MEM_rf, 38'h0);
      check("rst_after_fwd", MEM_fwd, 39'h0);
      next_cycle();
    end
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
